// File: rtl/psr_pkg.sv
// Shared types for the parametrised preset/clear shift register.
// Optional macro used elsewhere in this slice: PSR_ROTATE_EN.
package psr_pkg;

  typedef enum logic [1:0] {
    PSR_HOLD = 2'b00,
    PSR_SHL  = 2'b01,
    PSR_SHR  = 2'b10,
    PSR_LOAD = 2'b11
  } psr_mode_e;

  typedef enum logic [1:0] {
    PSR_LOADED   = 2'b00,
    PSR_SHIFTING = 2'b01,
    PSR_FULL     = 2'b10
  } psr_cnt_state_e;

  function automatic logic psr_is_shift(input psr_mode_e m);
    return (m == PSR_SHL) || (m == PSR_SHR);
  endfunction

endpackage

// File: rtl/psr_shift_cnt.sv
// Saturating shift counter with a single done pulse on reaching WIDTH.
//
// state        | meaning
// PSR_LOADED   | counter cleared by a load or by clr (cnt = 0)
// PSR_SHIFTING | 0 < cnt < WIDTH
// PSR_FULL     | cnt = WIDTH, saturated; no further done pulses until a load
module psr_shift_cnt
  import psr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_i,
  input  logic             shift_i,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  psr_cnt_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // Next-state: load clears, shifts advance until saturated, done marks the final step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (load_i) begin
      state_d = PSR_LOADED;
      cnt_d   = '0;
    end else if (shift_i && (state_q != PSR_FULL)) begin
      cnt_d = cnt_q + CNT_ONE;
      if (cnt_q == CNT_LAST) begin
        state_d = PSR_FULL;
        done_d  = 1'b1;
      end else begin
        state_d = PSR_SHIFTING;
      end
    end
  end

  // Counter state registers; clr drops any pending done immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= PSR_LOADED;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign shift_cnt = cnt_q;
  assign done      = done_q;

endmodule

// File: rtl/param_preset_shift_reg.sv
// WIDTH-bit universal shift register with per-bit async reset pattern,
// synchronous set/clear masks and a shift counter.
// Define PSR_ROTATE_EN to add the rot port and rotate modes.
module param_preset_shift_reg
  import psr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] set_mask,
  input  logic [WIDTH-1:0] clr_mask,
`ifdef PSR_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             done
);

  psr_mode_e        mode_e;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] op_val;
  logic             load_op;
  logic             shift_op;

  assign mode_e = psr_mode_e'(mode);

  // Operation result, then masks; set is applied last so it dominates clear.
  always_comb begin
    op_val = q_q;
    if (en) begin
      case (mode_e)
        PSR_SHL: begin
`ifdef PSR_ROTATE_EN
          if (rot) op_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          else     op_val = {q_q[WIDTH-2:0], sin_l};
`else
          op_val = {q_q[WIDTH-2:0], sin_l};
`endif
        end
        PSR_SHR: begin
`ifdef PSR_ROTATE_EN
          if (rot) op_val = {q_q[0], q_q[WIDTH-1:1]};
          else     op_val = {sin_r, q_q[WIDTH-1:1]};
`else
          op_val = {sin_r, q_q[WIDTH-1:1]};
`endif
        end
        PSR_LOAD: op_val = d;
        default:  op_val = q_q;
      endcase
    end
    q_d = (op_val & ~clr_mask) | set_mask;
  end

  // Data register; clr presets/clears each bit from RESET_VAL.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) q_q <= RESET_VAL;
    else     q_q <= q_d;
  end

  assign load_op  = en && (mode_e == PSR_LOAD);
  assign shift_op = en && psr_is_shift(mode_e);

  psr_shift_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_shift_cnt (
    .clk       (clk),
    .clr       (clr),
    .load_i    (load_op),
    .shift_i   (shift_op),
    .shift_cnt (shift_cnt),
    .done      (done)
  );

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];

endmodule
